// File: rtl/note_if.sv
// Bundle of game-side signals between the note scheduler and its driver.
// The master drives spawn requests, frame ticks and fret buttons; the slave reports lane state.
interface note_if;
  logic        frame_tick;
  logic        spawn_valid;
  logic [2:0]  spawn_lane;
  logic        spawn_ready;
  logic [4:0]  strum;
  logic [4:0]  lane_active;
  logic [9:0]  x_pos_0;
  logic [9:0]  x_pos_1;
  logic [9:0]  x_pos_2;
  logic [9:0]  x_pos_3;
  logic [9:0]  x_pos_4;
  logic [9:0]  y_pos_0;
  logic [9:0]  y_pos_1;
  logic [9:0]  y_pos_2;
  logic [9:0]  y_pos_3;
  logic [9:0]  y_pos_4;
  logic [4:0]  hit_pulse;
  logic [4:0]  miss_pulse;
  logic [15:0] score;
  logic [7:0]  streak;

  modport master (
    output frame_tick, spawn_valid, spawn_lane, strum,
    input  spawn_ready, lane_active,
    input  x_pos_0, x_pos_1, x_pos_2, x_pos_3, x_pos_4,
    input  y_pos_0, y_pos_1, y_pos_2, y_pos_3, y_pos_4,
    input  hit_pulse, miss_pulse, score, streak
  );

  modport slave (
    input  frame_tick, spawn_valid, spawn_lane, strum,
    output spawn_ready, lane_active,
    output x_pos_0, x_pos_1, x_pos_2, x_pos_3, x_pos_4,
    output y_pos_0, y_pos_1, y_pos_2, y_pos_3, y_pos_4,
    output hit_pulse, miss_pulse, score, streak
  );
endinterface

// File: rtl/note_scheduler.sv
// Five-lane falling-note scheduler: spawns notes, moves them per frame, scores strums and misses.
// Optional streak multiplier is enabled by defining NOTE_STREAK_EN.
module note_scheduler #(
  parameter int SPEED     = 2,
  parameter int HIT_Y_MIN = 390,
  parameter int HIT_Y_MAX = 440,
  parameter int MISS_Y    = 480
) (
  input logic  clk,
  input logic  rst_n,
  note_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, FALL = 1'b1} lane_state_e;

  lane_state_e state_q [5];
  lane_state_e state_d [5];
  logic [9:0]  y_q     [5];
  logic [9:0]  y_d     [5];
  logic [10:0] y_next  [5];
  logic [4:0]  strum_q, strum_d;
  logic [4:0]  strum_edge;
  logic [4:0]  hit_q, hit_d;
  logic [4:0]  miss_q, miss_d;
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
  logic [2:0]  hit_count;
  logic [4:0]  gain;

  // Lane FSMs. Priority per lane: hit (pre-move y), then frame move/miss, then spawn.
  always_comb begin
    strum_d    = bus.strum;
    strum_edge = bus.strum & ~strum_q;
    hit_d      = '0;
    miss_d     = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      y_d[i]     = y_q[i];
      y_next[i]  = {1'b0, y_q[i]} + 11'(SPEED);
      if (state_q[i] == FALL) begin
        if (strum_edge[i] && (y_q[i] >= 10'(HIT_Y_MIN)) && (y_q[i] <= 10'(HIT_Y_MAX))) begin
          state_d[i] = IDLE;
          y_d[i]     = '0;
          hit_d[i]   = 1'b1;
        end else if (bus.frame_tick) begin
          if (y_next[i] > 11'(MISS_Y)) begin
            state_d[i] = IDLE;
            y_d[i]     = '0;
            miss_d[i]  = 1'b1;
          end else begin
            y_d[i] = y_next[i][9:0];
          end
        end
      end else if (bus.spawn_valid && (bus.spawn_lane == 3'(i))) begin
        state_d[i] = FALL;
        y_d[i]     = '0;
      end
    end
  end

  // Spawn handshake: a note launches on a cycle where spawn_valid and spawn_ready are both high;
  // spawn_ready depends only on reset and the addressed lane being idle, never on spawn_valid.
  always_comb begin
    bus.spawn_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ((bus.spawn_lane == 3'(i)) && (state_q[i] == IDLE)) begin
        bus.spawn_ready = rst_n;
      end
    end
  end

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < 5; i++) begin
      hit_count = hit_count + 3'(hit_d[i]);
    end
  end

`ifdef NOTE_STREAK_EN
  logic [7:0] streak_q, streak_d;
  logic [8:0] streak_sum;
  logic [2:0] mult;

  // Multiplier comes from the streak held before this cycle's hits.
  always_comb begin
    if (streak_q >= 8'd30)      mult = 3'd4;
    else if (streak_q >= 8'd20) mult = 3'd3;
    else if (streak_q >= 8'd10) mult = 3'd2;
    else                        mult = 3'd1;
    gain       = 5'(hit_count) * 5'(mult);
    streak_sum = {1'b0, streak_q} + 9'(hit_count);
    if (|miss_d)                   streak_d = '0;
    else if (streak_sum > 9'd255)  streak_d = 8'hFF;
    else                           streak_d = streak_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end

  assign bus.streak = streak_q;
`else
  always_comb gain = 5'(hit_count);
  assign bus.streak = '0;
`endif

  always_comb begin
    score_sum = {1'b0, score_q} + 17'(gain);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= IDLE;
        y_q[i]     <= '0;
      end
      strum_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      score_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        y_q[i]     <= y_d[i];
      end
      strum_q <= strum_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bus.lane_active[i] = (state_q[i] == FALL);
    end
  end

  assign bus.x_pos_0    = 10'd150;
  assign bus.x_pos_1    = 10'd225;
  assign bus.x_pos_2    = 10'd300;
  assign bus.x_pos_3    = 10'd375;
  assign bus.x_pos_4    = 10'd450;
  assign bus.y_pos_0    = y_q[0];
  assign bus.y_pos_1    = y_q[1];
  assign bus.y_pos_2    = y_q[2];
  assign bus.y_pos_3    = y_q[3];
  assign bus.y_pos_4    = y_q[4];
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus randomized traffic against a lane-level model.
module tb_note_scheduler;
  localparam int SPEED     = 2;
  localparam int HIT_Y_MIN = 390;
  localparam int HIT_Y_MAX = 440;
  localparam int MISS_Y    = 480;
`ifdef NOTE_STREAK_EN
  localparam bit STREAK_EN = 1'b1;
`else
  localparam bit STREAK_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  note_if bus ();

  note_scheduler #(
    .SPEED(SPEED), .HIT_Y_MIN(HIT_Y_MIN), .HIT_Y_MAX(HIT_Y_MAX), .MISS_Y(MISS_Y)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int errors;

  logic [9:0] dut_y [5];
  logic [9:0] dut_x [5];
  assign dut_y[0] = bus.y_pos_0;
  assign dut_y[1] = bus.y_pos_1;
  assign dut_y[2] = bus.y_pos_2;
  assign dut_y[3] = bus.y_pos_3;
  assign dut_y[4] = bus.y_pos_4;
  assign dut_x[0] = bus.x_pos_0;
  assign dut_x[1] = bus.x_pos_1;
  assign dut_x[2] = bus.x_pos_2;
  assign dut_x[3] = bus.x_pos_3;
  assign dut_x[4] = bus.x_pos_4;

  // reference model: one falling note per lane, tracked as plain integers
  bit         m_active [5];
  int         m_y      [5];
  logic [4:0] m_hit;
  logic [4:0] m_miss;
  logic [4:0] m_prev;
  int         m_score;
  int         m_streak;

  function automatic int x_of(int lane);
    return 150 + 75 * lane;
  endfunction

  function automatic logic [4:0] act_vec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_active[i];
    return v;
  endfunction

  function automatic bit exp_ready();
    if (!rst_n || bus.spawn_lane > 3'd4) return 1'b0;
    return !m_active[bus.spawn_lane];
  endfunction

  task automatic model_step();
    int  n;
    int  mult;
    bit  any_miss;
    n        = 0;
    any_miss = 1'b0;
    m_hit    = '0;
    m_miss   = '0;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        m_active[i] = 1'b0;
        m_y[i]      = 0;
      end
      m_prev   = '0;
      m_score  = 0;
      m_streak = 0;
      return;
    end
    for (int i = 0; i < 5; i++) begin
      bit pressed;
      pressed = bus.strum[i] && !m_prev[i];
      if (m_active[i]) begin
        if (pressed && m_y[i] >= HIT_Y_MIN && m_y[i] <= HIT_Y_MAX) begin
          m_active[i] = 1'b0;
          m_y[i]      = 0;
          m_hit[i]    = 1'b1;
          n++;
        end else if (bus.frame_tick) begin
          if (m_y[i] + SPEED > MISS_Y) begin
            m_active[i] = 1'b0;
            m_y[i]      = 0;
            m_miss[i]   = 1'b1;
            any_miss    = 1'b1;
          end else begin
            m_y[i] = m_y[i] + SPEED;
          end
        end
      end else if (bus.spawn_valid && int'(bus.spawn_lane) == i) begin
        m_active[i] = 1'b1;
        m_y[i]      = 0;
      end
    end
    m_prev = bus.strum;
    mult   = 1;
    if (STREAK_EN) mult = 1 + ((m_streak / 10 > 3) ? 3 : m_streak / 10);
    m_score = m_score + n * mult;
    if (m_score > 65535) m_score = 65535;
    if (STREAK_EN) begin
      if (any_miss) m_streak = 0;
      else          m_streak = (m_streak + n > 255) ? 255 : m_streak + n;
    end
  endtask

  // driver tasks
  task automatic set_in(bit r, bit tick, bit sv, logic [2:0] lane, logic [4:0] st);
    rst_n           = r;
    bus.frame_tick  = tick;
    bus.spawn_valid = sv;
    bus.spawn_lane  = lane;
    bus.strum       = st;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    advance();
    advance();
  endtask

  task automatic run_note_to(int lane, int target);
    set_in(1'b1, 1'b0, 1'b1, 3'(lane), 5'd0);
    advance();
    for (int k = 0; k < 300 && m_active[lane] && m_y[lane] != target; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      advance();
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 4)), 5'($urandom_range(0, 31)));
      vectors++;
      if (bus.spawn_ready !== 1'b0) begin
        errors++; $display("FAIL reset_spawn_ready got=%b exp=0", bus.spawn_ready);
      end
      advance();
      vectors++;
      if (bus.lane_active !== 5'd0 || bus.hit_pulse !== 5'd0 || bus.miss_pulse !== 5'd0) begin
        errors++;
        $display("FAIL reset_flags active=%b hit=%b miss=%b exp=0", bus.lane_active, bus.hit_pulse, bus.miss_pulse);
      end
      vectors++;
      if (bus.score !== 16'd0 || bus.streak !== 8'd0) begin
        errors++; $display("FAIL reset_score score=%0d streak=%0d exp=0", bus.score, bus.streak);
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (dut_y[i] !== 10'd0 || dut_x[i] !== 10'(x_of(i))) begin
          errors++; $display("FAIL reset_pos lane=%0d x=%0d y=%0d exp x=%0d y=0", i, dut_x[i], dut_y[i], x_of(i));
        end
      end
    end
  endtask

  task automatic test_spawn();
    set_in(1'b1, 1'b0, 1'b1, 3'd2, 5'd0);
    vectors++;
    if (bus.spawn_ready !== 1'b1) begin
      errors++; $display("FAIL spawn_ready_idle got=%b exp=1", bus.spawn_ready);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b0, 3'd2, 5'd0);
    vectors++;
    if (bus.lane_active !== 5'b00100 || bus.y_pos_2 !== 10'd0) begin
      errors++; $display("FAIL spawn_lane2 active=%b y=%0d exp 00100/0", bus.lane_active, bus.y_pos_2);
    end
    vectors++;
    if (bus.spawn_ready !== 1'b0) begin
      errors++; $display("FAIL spawn_ready_busy got=%b exp=0", bus.spawn_ready);
    end
    set_in(1'b1, 1'b0, 1'b1, 3'd6, 5'd0);
    vectors++;
    if (bus.spawn_ready !== 1'b0) begin
      errors++; $display("FAIL spawn_ready_lane6 got=%b exp=0", bus.spawn_ready);
    end
  endtask

  task automatic test_hit();
    for (int k = 0; k < 195; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      advance();
    end
    vectors++;
    if (bus.y_pos_2 !== 10'd390) begin
      errors++; $display("FAIL hit_y_before got=%0d exp=390", bus.y_pos_2);
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'b00100);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'b00100 || bus.score !== 16'd1 || bus.lane_active[2] !== 1'b0 || bus.y_pos_2 !== 10'd0) begin
      errors++;
      $display("FAIL hit_lane2 hit=%b score=%0d active=%b y=%0d exp 00100/1/0/0",
               bus.hit_pulse, bus.score, bus.lane_active, bus.y_pos_2);
    end
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'b00100);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'd0 || bus.score !== 16'd1) begin
      errors++; $display("FAIL hit_held hit=%b score=%0d exp 0/1", bus.hit_pulse, bus.score);
    end
  endtask

  task automatic test_miss();
    run_note_to(0, 480);
    vectors++;
    if (bus.y_pos_0 !== 10'd480 || bus.lane_active[0] !== 1'b1 || bus.miss_pulse !== 5'd0) begin
      errors++; $display("FAIL miss_at_480 y=%0d active=%b miss=%b", bus.y_pos_0, bus.lane_active, bus.miss_pulse);
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    advance();
    vectors++;
    if (bus.miss_pulse !== 5'b00001 || bus.lane_active[0] !== 1'b0 || bus.y_pos_0 !== 10'd0 || bus.streak !== 8'd0) begin
      errors++;
      $display("FAIL miss_lane0 miss=%b active=%b y=%0d streak=%0d exp 00001/0/0/0",
               bus.miss_pulse, bus.lane_active, bus.y_pos_0, bus.streak);
    end
  endtask

  task automatic test_window();
    int s0;
    s0 = m_score;
    run_note_to(1, 388);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'b00010);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'd0 || bus.y_pos_1 !== 10'd388 || bus.lane_active[1] !== 1'b1 || bus.score !== 16'(s0)) begin
      errors++; $display("FAIL window_388 hit=%b y=%0d score=%0d exp 0/388/%0d", bus.hit_pulse, bus.y_pos_1, bus.score, s0);
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    advance();
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'b00010);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'b00010 || bus.score !== 16'(m_score)) begin
      errors++; $display("FAIL window_390 hit=%b score=%0d exp 00010/%0d", bus.hit_pulse, bus.score, m_score);
    end
    run_note_to(3, 442);
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'b01000);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'd0 || bus.y_pos_3 !== 10'd442 || bus.lane_active[3] !== 1'b1) begin
      errors++; $display("FAIL window_442 hit=%b y=%0d active=%b exp 0/442/1", bus.hit_pulse, bus.y_pos_3, bus.lane_active);
    end
    for (int k = 0; k < 30 && bus.miss_pulse[3] !== 1'b1; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      advance();
    end
    vectors++;
    if (bus.miss_pulse !== 5'b01000 || bus.lane_active[3] !== 1'b0) begin
      errors++; $display("FAIL window_miss3 miss=%b active=%b exp 01000/0", bus.miss_pulse, bus.lane_active);
    end
  endtask

  task automatic test_edge_440();
    run_note_to(4, 440);
    vectors++;
    if (bus.y_pos_4 !== 10'd440) begin
      errors++; $display("FAIL edge_y got=%0d exp=440", bus.y_pos_4);
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'b10000);
    advance();
    vectors++;
    if (bus.hit_pulse !== 5'b10000 || bus.miss_pulse !== 5'd0 || bus.y_pos_4 !== 10'd0 || bus.lane_active[4] !== 1'b0) begin
      errors++;
      $display("FAIL edge_440 hit=%b miss=%b y=%0d active=%b exp 10000/0/0/0",
               bus.hit_pulse, bus.miss_pulse, bus.y_pos_4, bus.lane_active);
    end
    set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
    advance();
  endtask

  task automatic test_reset_mid_fall();
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 5'd0); advance();
    set_in(1'b1, 1'b0, 1'b1, 3'd1, 5'd0); advance();
    set_in(1'b1, 1'b0, 1'b1, 3'd3, 5'd0); advance();
    for (int k = 0; k < 50; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      advance();
    end
    vectors++;
    if (bus.lane_active !== 5'b01011) begin
      errors++; $display("FAIL midfall_setup active=%b exp=01011", bus.lane_active);
    end
    for (int c = 0; c < 2; c++) begin
      set_in(1'b0, 1'b1, 1'b0, 3'd0, 5'd0);
      advance();
      vectors++;
      if (bus.lane_active !== 5'd0 || bus.miss_pulse !== 5'd0 || bus.score !== 16'd0 ||
          bus.y_pos_0 !== 10'd0 || bus.y_pos_1 !== 10'd0 || bus.y_pos_3 !== 10'd0) begin
        errors++;
        $display("FAIL midfall_reset active=%b miss=%b score=%0d y0=%0d y1=%0d y3=%0d exp all 0",
                 bus.lane_active, bus.miss_pulse, bus.score, bus.y_pos_0, bus.y_pos_1, bus.y_pos_3);
      end
    end
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    advance();
    vectors++;
    if (bus.miss_pulse !== 5'd0 || bus.lane_active !== 5'd0) begin
      errors++; $display("FAIL midfall_release miss=%b active=%b exp 0/0", bus.miss_pulse, bus.lane_active);
    end
  endtask

  task automatic test_streak();
    int exp10, exp11, exps;
    exp10 = 10;
    exp11 = STREAK_EN ? 12 : 11;
    exps  = STREAK_EN ? 11 : 0;
    do_reset();
    for (int h = 1; h <= 11; h++) begin
      run_note_to(1, 390);
      set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'b00010);
      advance();
      set_in(1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
      if (h == 10) begin
        vectors++;
        if (bus.score !== 16'(exp10)) begin
          errors++; $display("FAIL streak_score10 got=%0d exp=%0d", bus.score, exp10);
        end
      end
      advance();
    end
    vectors++;
    if (bus.score !== 16'(exp11) || bus.streak !== 8'(exps)) begin
      errors++; $display("FAIL streak_score11 score=%0d streak=%0d exp %0d/%0d", bus.score, bus.streak, exp11, exps);
    end
    run_note_to(2, 480);
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    advance();
    vectors++;
    if (bus.miss_pulse !== 5'b00100 || bus.streak !== 8'd0 || bus.score !== 16'(exp11)) begin
      errors++; $display("FAIL streak_clear miss=%b streak=%0d score=%0d exp 00100/0/%0d",
                         bus.miss_pulse, bus.streak, bus.score, exp11);
    end
  endtask

  task automatic test_random();
    logic [4:0] st;
    st = '0;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 7) == 0) st = 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 499) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), st);
      vectors++;
      if (bus.spawn_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.spawn_ready, exp_ready());
      end
      advance();
      vectors++;
      if (bus.lane_active !== act_vec() || bus.hit_pulse !== m_hit || bus.miss_pulse !== m_miss) begin
        errors++;
        $display("FAIL rand_flags cyc=%0d act=%b/%b hit=%b/%b miss=%b/%b (got/exp)",
                 c, bus.lane_active, act_vec(), bus.hit_pulse, m_hit, bus.miss_pulse, m_miss);
      end
      vectors++;
      if (bus.score !== 16'(m_score) || bus.streak !== 8'(m_streak)) begin
        errors++; $display("FAIL rand_score cyc=%0d score=%0d exp=%0d streak=%0d exp=%0d",
                           c, bus.score, m_score, bus.streak, m_streak);
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (dut_y[i] !== 10'(m_y[i]) || dut_x[i] !== 10'(x_of(i))) begin
          errors++; $display("FAIL rand_pos cyc=%0d lane=%0d y=%0d exp=%0d x=%0d exp=%0d",
                             c, i, dut_y[i], m_y[i], dut_x[i], x_of(i));
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    m_prev  = '0;
    m_score = 0;
    m_streak = 0;
    for (int i = 0; i < 5; i++) begin
      m_active[i] = 1'b0;
      m_y[i]      = 0;
    end
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_spawn();
    test_hit();
    test_miss();
    test_window();
    test_edge_440();
    test_reset_mid_fall();
    test_streak();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
